// File: rtl/regfile_defs.sv
// Shared defaults and helpers for the multi-port register file.
package regfile_defs;

  localparam int unsigned DefDataW = 32;
  localparam int unsigned DefAddrW = 5;

  // Address of the optional hardwired-zero register.
  localparam int unsigned ZERO_ADDR = 0;

  // LSB of port `port` in a flattened bus of `width`-bit fields.
  function automatic int unsigned portLsb(input int unsigned port, input int unsigned width);
    return port * width;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// Busy-bit scoreboard: set at issue, cleared at writeback, looked up per read port.
module regfile_sb
  import regfile_defs::*;
#(
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD-1:0]        rbusy
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [Depth-1:0] busyQ;
  logic [Depth-1:0] busyD;

  // Next busy state: a new issue outranks a writeback on the same register.
  always_comb begin
    busyD = busyQ;
    for (int unsigned a = 0; a < Depth; a++) begin
      if (we0 && (wa0 == ADDR_W'(a))) begin
        busyD[a] = 1'b0;
      end
      if (we1 && (wa1 == ADDR_W'(a))) begin
        busyD[a] = 1'b0;
      end
      if (sb_set && (sb_addr == ADDR_W'(a))) begin
        busyD[a] = 1'b1;
      end
      if (ZERO_REG && (a == ZERO_ADDR)) begin
        busyD[a] = 1'b0;
      end
    end
  end

  // Busy bits, cleared immediately on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busyQ <= '0;
    end else begin
      busyQ <= busyD;
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : gRdBusy
    logic [ADDR_W-1:0] addr;
    logic              wrHit;
    logic              setHit;
    logic              busyBit;

    assign addr = ra[portLsb(i, ADDR_W) +: ADDR_W];

    // Lookup; a same-cycle writeback hides the busy bit unless it is re-issued.
    always_comb begin
      wrHit   = (we0 && (wa0 == addr)) || (we1 && (wa1 == addr));
      setHit  = sb_set && (sb_addr == addr);
      busyBit = busyQ[addr];
      if (BYPASS && wrHit && !setHit) begin
        busyBit = 1'b0;
      end
      if (ZERO_REG && (addr == ADDR_W'(ZERO_ADDR))) begin
        busyBit = 1'b0;
      end
    end

    assign rbusy[i] = busyBit;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational
// read ports, optional zero register, optional write bypass and busy scoreboard.
module regfile_mp
  import regfile_defs::*;
#(
  parameter int unsigned DATA_W   = DefDataW,
  parameter int unsigned ADDR_W   = DefAddrW,
  parameter int unsigned NUM_RD   = 2,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          BYPASS   = 1'b1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we0,
  input  logic [ADDR_W-1:0]        wa0,
  input  logic [DATA_W-1:0]        wd0,
  input  logic                     we1,
  input  logic [ADDR_W-1:0]        wa1,
  input  logic [DATA_W-1:0]        wd1,
  input  logic [NUM_RD*ADDR_W-1:0] ra,
  output logic [NUM_RD*DATA_W-1:0] rd,
  output logic [NUM_RD-1:0]        rbusy,
  input  logic                     sb_set,
  input  logic [ADDR_W-1:0]        sb_addr,
  output logic                     wr_collide
);

  localparam int unsigned Depth = 2 ** ADDR_W;

  logic [DATA_W-1:0] regQ [Depth];
  logic              collideQ;

  // Storage; port 1 is checked first so it wins an address collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned a = 0; a < Depth; a++) begin
        regQ[a] <= '0;
      end
    end else begin
      for (int unsigned a = 0; a < Depth; a++) begin
        if (ZERO_REG && (a == ZERO_ADDR)) begin
          regQ[a] <= '0;
        end else if (we1 && (wa1 == ADDR_W'(a))) begin
          regQ[a] <= wd1;
        end else if (we0 && (wa0 == ADDR_W'(a))) begin
          regQ[a] <= wd0;
        end
      end
    end
  end

  // One-cycle flag for a dropped port-0 write (includes the zero register).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      collideQ <= 1'b0;
    end else begin
      collideQ <= we0 && we1 && (wa0 == wa1);
    end
  end

  assign wr_collide = collideQ;

  for (genvar i = 0; i < NUM_RD; i++) begin : gRdPort
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;

    assign addr = ra[portLsb(i, ADDR_W) +: ADDR_W];

    // Read mux with forwarding; bypass is suppressed in reset so rd reads 0.
    always_comb begin
      data = regQ[addr];
      if (BYPASS && !rst) begin
        if (we1 && (wa1 == addr)) begin
          data = wd1;
        end else if (we0 && (wa0 == addr)) begin
          data = wd0;
        end
      end
      if (ZERO_REG && (addr == ADDR_W'(ZERO_ADDR))) begin
        data = '0;
      end
    end

    assign rd[portLsb(i, DATA_W) +: DATA_W] = data;
  end

  regfile_sb #(
    .ADDR_W   (ADDR_W),
    .NUM_RD   (NUM_RD),
    .ZERO_REG (ZERO_REG),
    .BYPASS   (BYPASS)
  ) uSb (
    .clk     (clk),
    .rst     (rst),
    .we0     (we0),
    .wa0     (wa0),
    .we1     (we1),
    .wa1     (wa1),
    .sb_set  (sb_set),
    .sb_addr (sb_addr),
    .ra      (ra),
    .rbusy   (rbusy)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised bench for regfile_mp: instance A uses the default configuration,
// instance B is the wide, 4-port, no-zero-register, no-bypass configuration.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Instance A: DATA_W 32, ADDR_W 5, NUM_RD 2, ZERO_REG 1, BYPASS 1.
  logic        weA0, weA1, sbSetA, collA;
  logic [4:0]  waA0, waA1, sbAddrA;
  logic [31:0] wdA0, wdA1;
  logic [9:0]  raA;
  logic [63:0] rdA;
  logic [1:0]  rbusyA;

  // Instance B: DATA_W 64, ADDR_W 4, NUM_RD 4, ZERO_REG 0, BYPASS 0.
  logic         weB0, weB1, sbSetB, collB;
  logic [3:0]   waB0, waB1, sbAddrB;
  logic [63:0]  wdB0, wdB1;
  logic [15:0]  raB;
  logic [255:0] rdB;
  logic [3:0]   rbusyB;

  regfile_mp #(
    .DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1)
  ) dutA (
    .clk(clk), .rst(rst),
    .we0(weA0), .wa0(waA0), .wd0(wdA0),
    .we1(weA1), .wa1(waA1), .wd1(wdA1),
    .ra(raA), .rd(rdA), .rbusy(rbusyA),
    .sb_set(sbSetA), .sb_addr(sbAddrA), .wr_collide(collA)
  );

  regfile_mp #(
    .DATA_W(64), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1'b0), .BYPASS(1'b0)
  ) dutB (
    .clk(clk), .rst(rst),
    .we0(weB0), .wa0(waB0), .wd0(wdB0),
    .we1(weB1), .wa1(waB1), .wd1(wdB1),
    .ra(raB), .rd(rdB), .rbusy(rbusyB),
    .sb_set(sbSetB), .sb_addr(sbAddrB), .wr_collide(collB)
  );

  // Reference state: plain arrays of register contents and busy flags.
  logic [31:0] memA [32];
  bit          busyA [32];
  bit          colA;
  logic [63:0] memB [16];
  bit          busyB [16];
  bit          colB;

  int vectors = 0;
  int miscompares = 0;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic resetModel();
    for (int a = 0; a < 32; a++) begin
      memA[a]  = '0;
      busyA[a] = 1'b0;
    end
    for (int a = 0; a < 16; a++) begin
      memB[a]  = '0;
      busyB[a] = 1'b0;
    end
    colA = 1'b0;
    colB = 1'b0;
  endtask

  function automatic logic [31:0] expRdA(input logic [4:0] addr);
    if (addr == 5'd0) return 32'd0;
    if (!rst && weA1 && waA1 == addr) return wdA1;
    if (!rst && weA0 && waA0 == addr) return wdA0;
    return memA[addr];
  endfunction

  function automatic logic expBusyA(input logic [4:0] addr);
    bit written;
    if (addr == 5'd0) return 1'b0;
    written = (weA0 && waA0 == addr) || (weA1 && waA1 == addr);
    if (written && !(sbSetA && sbAddrA == addr)) return 1'b0;
    return busyA[addr];
  endfunction

  task automatic checkAll();
    logic [4:0] addrA;
    logic [3:0] addrB;
    for (int p = 0; p < 2; p++) begin
      addrA = raA[p*5 +: 5];
      checkVal($sformatf("A rd%0d @%0d", p, addrA), 64'(rdA[p*32 +: 32]), 64'(expRdA(addrA)));
      checkVal($sformatf("A rbusy%0d @%0d", p, addrA), 64'(rbusyA[p]), 64'(expBusyA(addrA)));
    end
    checkVal("A wr_collide", 64'(collA), 64'(colA));
    for (int p = 0; p < 4; p++) begin
      addrB = raB[p*4 +: 4];
      checkVal($sformatf("B rd%0d @%0d", p, addrB), rdB[p*64 +: 64], memB[addrB]);
      checkVal($sformatf("B rbusy%0d @%0d", p, addrB), 64'(rbusyB[p]), 64'(busyB[addrB]));
    end
    checkVal("B wr_collide", 64'(collB), 64'(colB));
  endtask

  // Apply the clock-edge rules to the reference state.
  task automatic updateModels();
    colA = weA0 && weA1 && (waA0 == waA1);
    if (weA0 && waA0 != 5'd0) memA[waA0] = wdA0;
    if (weA1 && waA1 != 5'd0) memA[waA1] = wdA1;
    if (weA0) busyA[waA0] = 1'b0;
    if (weA1) busyA[waA1] = 1'b0;
    if (sbSetA && sbAddrA != 5'd0) busyA[sbAddrA] = 1'b1;

    colB = weB0 && weB1 && (waB0 == waB1);
    if (weB0) memB[waB0] = wdB0;
    if (weB1) memB[waB1] = wdB1;
    if (weB0) busyB[waB0] = 1'b0;
    if (weB1) busyB[waB1] = 1'b0;
    if (sbSetB) busyB[sbAddrB] = 1'b1;
  endtask

  // Inputs are set at the negedge; check 1 unit later, then advance the model.
  task automatic step();
    #1;
    checkAll();
    @(posedge clk);
    if (rst) resetModel();
    else updateModels();
    @(negedge clk);
  endtask

  task automatic idle();
    weA0 = 0; weA1 = 0; sbSetA = 0; waA0 = '0; waA1 = '0; sbAddrA = '0;
    wdA0 = '0; wdA1 = '0;
    weB0 = 0; weB1 = 0; sbSetB = 0; waB0 = '0; waB1 = '0; sbAddrB = '0;
    wdB0 = '0; wdB1 = '0;
  endtask

  function automatic logic [4:0] pickA();
    if ($urandom_range(0, 3) == 0) return 5'($urandom);
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic randInputs();
    weA0 = 1'($urandom_range(0, 1));
    weA1 = 1'($urandom_range(0, 1));
    waA0 = pickA();
    waA1 = pickA();
    wdA0 = $urandom;
    wdA1 = $urandom;
    raA  = {pickA(), pickA()};
    sbSetA  = ($urandom_range(0, 2) == 0);
    sbAddrA = pickA();
    weB0 = 1'($urandom_range(0, 1));
    weB1 = 1'($urandom_range(0, 1));
    waB0 = 4'($urandom);
    waB1 = 4'($urandom);
    wdB0 = {$urandom, $urandom};
    wdB1 = {$urandom, $urandom};
    raB  = 16'($urandom);
    sbSetB  = ($urandom_range(0, 2) == 0);
    sbAddrB = 4'($urandom);
    rst = ($urandom_range(0, 999) == 0);
  endtask

  initial begin
    rst = 1'b1;
    idle();
    raA = '0;
    raB = '0;
    resetModel();
    @(negedge clk);
    step();
    rst = 1'b0;

    // Basic write of 5: forwarded on A in the same cycle, old value on B.
    weA0 = 1; waA0 = 5'd5; wdA0 = 32'hDEAD_BEEF; raA = {5'd5, 5'd5};
    weB0 = 1; waB0 = 4'd5; wdB0 = 64'hDEAD_BEEF; raB = {4'd5, 4'd5, 4'd5, 4'd5};
    step();
    idle();
    step();

    // Collision on 7: port 1 wins, flag for exactly one cycle.
    weA0 = 1; weA1 = 1; waA0 = 5'd7; waA1 = 5'd7; wdA0 = 32'h1111; wdA1 = 32'h2222;
    weB0 = 1; weB1 = 1; waB0 = 4'd7; waB1 = 4'd7; wdB0 = 64'h1111; wdB1 = 64'h2222;
    raA = {5'd5, 5'd7};
    raB = {4'd0, 4'd5, 4'd7, 4'd7};
    step();
    idle();
    step();
    step();

    // Zero register: write and issue to address 0.
    weA1 = 1; waA1 = 5'd0; wdA1 = 32'hFFFF_FFFF; sbSetA = 1; sbAddrA = 5'd0;
    weB1 = 1; waB1 = 4'd0; wdB1 = 64'hFFFF_FFFF; sbSetB = 1; sbAddrB = 4'd0;
    raA = {5'd0, 5'd0};
    raB = {4'd0, 4'd0, 4'd7, 4'd0};
    step();
    idle();
    step();

    // Scoreboard on 9: set, observe, set+write, write alone.
    raA = {5'd5, 5'd9};
    raB = {4'd9, 4'd9, 4'd9, 4'd9};
    sbSetA = 1; sbAddrA = 5'd9; sbSetB = 1; sbAddrB = 4'd9;
    step();
    idle();
    step();
    sbSetA = 1; sbAddrA = 5'd9; weA0 = 1; waA0 = 5'd9; wdA0 = 32'h9999;
    sbSetB = 1; sbAddrB = 4'd9; weB0 = 1; waB0 = 4'd9; wdB0 = 64'h9999;
    step();
    idle();
    step();
    weA1 = 1; waA1 = 5'd9; wdA1 = 32'h0909;
    weB1 = 1; waB1 = 4'd9; wdB1 = 64'h0909;
    step();
    idle();
    step();

    // Mid-operation reset with data present: everything reads zero at once.
    raA = {5'd7, 5'd5};
    raB = {4'd0, 4'd9, 4'd7, 4'd5};
    step();
    rst = 1'b1;
    resetModel();
    step();
    rst = 1'b0;
    step();

    // Randomised traffic, with occasional resets.
    for (int n = 0; n < 10000; n++) begin
      randInputs();
      if (rst) resetModel();
      step();
    end
    rst = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port register file for the pipelined datapath. Next generation of the single-write, dual-read file.
- Provides NUM_RD combinational read ports and two synchronous write ports with fixed priority.
- Optional hardwired-zero register 0 and optional write-to-read bypass.
- Per-register busy scoreboard (set at issue, cleared at writeback) so the hazard unit can stall on pending producers.

Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, read ports (1..4); read buses flattened, port i at bits [i*W +: W]
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes, never busy
- BYPASS, 1, 1 = same-cycle write data forwarded to matching read ports

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  reset, asynchronous, active-high
- we0  in  1  write port 0 enable (low priority)
- wa0  in  ADDR_W  write port 0 address
- wd0  in  DATA_W  write port 0 data
- we1  in  1  write port 1 enable (high priority)
- wa1  in  ADDR_W  write port 1 address
- wd1  in  DATA_W  write port 1 data
- ra  in  NUM_RD*ADDR_W  read addresses
- rd  out  NUM_RD*DATA_W  read data, combinational
- rbusy  out  NUM_RD  busy bit of each read address, combinational
- sb_set  in  1  mark register sb_addr busy (instruction issue)
- sb_addr  in  ADDR_W  scoreboard set address
- wr_collide  out  1  registered flag: previous cycle had we0 & we1 to the same address

Behaviour:
- Reset (async, immediate):
  - all registers = 0; all busy bits = 0; wr_collide = 0.
  - rd and rbusy reflect the reset state combinationally (rd = 0, rbusy = 0).
- Write timing: on posedge, Reg[wa0] <= wd0 if we0, and Reg[wa1] <= wd1 if we1. No negedge logic.
- Write conflict (we0 & we1 & wa0 == wa1):
  - port 1 wins; port 0's write is dropped.
  - wr_collide = 1 in the following cycle, for exactly one cycle per colliding cycle.
- ZERO_REG = 1:
  - writes to address 0 are discarded.
  - rd for address 0 = 0 and rbusy = 0, regardless of bypass.
  - sb_set to address 0 is ignored.
  - wr_collide still asserts on an address-0 collision.
- Read latency: 0 cycles (combinational from ra and state).
- BYPASS = 1:
  - if we1 & wa1 == ra[i], then rd[i] = wd1.
  - else if we0 & wa0 == ra[i], then rd[i] = wd0.
  - else rd[i] = stored value.
- BYPASS = 0: rd returns the stored value only; the new value is visible the cycle after the write.
- Scoreboard, per address, evaluated on posedge:
  - clear if (we0 & wa0 == a) or (we1 & wa1 == a).
  - set if sb_set & sb_addr == a.
  - set wins over clear on the same address in the same cycle (a new producer was issued).
- rbusy[i]:
  - = stored busy bit of ra[i].
  - when BYPASS = 1, forced to 0 if a write to ra[i] occurs in the current cycle and no sb_set targets the same address.
- Reset mid-operation: state is cleared immediately; pending writes and sb_set in that cycle are lost.
- Width rules: no arithmetic; addresses are used unsigned and always in range (depth = 2**ADDR_W).

Decomposition:
- Shared package/include `regfile_defs`: default DATA_W/ADDR_W, the ZERO_ADDR constant, and the read-port slice macro.
- One natural sub-module: `regfile_sb`, the busy-bit scoreboard (set/clear priority logic plus the rbusy lookup). Storage and bypass stay in the top.

Test Plan:
- Reset then read: assert rst mid-cycle with registers holding data → rd = 0 and rbusy = 0 immediately, wr_collide = 0.
- Basic write/read: we0, wa0 = 5, wd0 = 0xDEADBEEF; next cycle ra[0] = 5 → rd[0] = 0xDEADBEEF. With BYPASS = 1, the same-cycle read also returns 0xDEADBEEF; with BYPASS = 0 it returns the old value 0.
- Collision: we0 & we1, both addresses 7, wd0 = 0x1111, wd1 = 0x2222 → Reg7 = 0x2222; wr_collide = 1 for one cycle; same-cycle bypass read of 7 = 0x2222.
- Zero register: we1, wa1 = 0, wd1 = 0xFFFF_FFFF, plus sb_set to 0 → rd for address 0 stays 0 and rbusy = 0. Repeat with ZERO_REG = 0 → reads 0xFFFF_FFFF.
- Scoreboard: sb_set on address 9 → rbusy = 1 from the next cycle. A write to 9 clears it, and rbusy = 0 already in the write cycle when BYPASS = 1. sb_set and write to 9 in the same cycle → busy remains 1.
- Parameter sweep: NUM_RD = 4, DATA_W = 64, ADDR_W = 4; random writes checked against a reference model for 10k cycles → no mismatch on any of the 4 ports.
